// File: rtl/quad_decoder.sv
// Quadrature decoder: synchronizes the raw A/B encoder phases, decodes Gray-code
// transitions into up/down steps and keeps a wrapping position count.
module quad_decoder #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt,
  output logic             dir,
  output logic             step,
  output logic             err
);

  typedef enum logic {
    SETTLE = 1'b0,
    RUN    = 1'b1
  } state_t;

  localparam logic [2:0] SETTLE_LAST = 3'(SYNC_STAGES);

  logic [SYNC_STAGES-1:0] sync_a;
  logic [SYNC_STAGES-1:0] sync_b;
  logic [1:0]             cur;
  logic [1:0]             prev;
  logic [2:0]             settle_cnt;
  state_t                 state;
  logic                   is_up;
  logic                   is_down;
  logic                   is_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= {sync_a[SYNC_STAGES-2:0], a};
      sync_b <= {sync_b[SYNC_STAGES-2:0], b};
    end
  end

  assign cur = {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1]};

  // Transition table keyed on {prev, cur}; up order is 00 -> 10 -> 11 -> 01 -> 00.
  always_comb begin
    is_up   = 1'b0;
    is_down = 1'b0;
    case ({prev, cur})
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: is_up   = 1'b1;
      4'b10_00, 4'b11_10, 4'b01_11, 4'b00_01: is_down = 1'b1;
      default: ;
    endcase
    is_bad = ((prev ^ cur) == 2'b11);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SETTLE;
      settle_cnt <= '0;
      prev       <= 2'b00;
      cnt        <= '0;
      dir        <= 1'b0;
      step       <= 1'b0;
      err        <= 1'b0;
    end else begin
      step <= 1'b0;
      case (state)
        SETTLE: begin
          // Latch the resting phase so a non-00 encoder position does not count.
          if (settle_cnt == SETTLE_LAST) begin
            prev  <= cur;
            state <= RUN;
          end else begin
            settle_cnt <= settle_cnt + 3'd1;
          end
          if (clr) begin
            cnt <= '0;
            err <= 1'b0;
          end
        end
        RUN: begin
          prev <= cur;
          if (clr) begin
            cnt <= '0;
            err <= 1'b0;
          end else if (is_up) begin
            cnt  <= cnt + WIDTH'(1);
            dir  <= 1'b0;
            step <= 1'b1;
          end else if (is_down) begin
            cnt  <= cnt - WIDTH'(1);
            dir  <= 1'b1;
            step <= 1'b1;
          end else if (is_bad) begin
            err <= 1'b1;
          end
        end
        default: state <= SETTLE;
      endcase
    end
  end

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder: phase-position model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_quad_decoder;

  localparam int WIDTH = 8;
  localparam int SYNC  = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             a;
  logic             b;
  logic             clr;
  logic [WIDTH-1:0] cnt;
  logic             dir;
  logic             step;
  logic             err;

  int checks = 0;
  int passes = 0;

  quad_decoder #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .clr(clr),
    .cnt(cnt), .dir(dir), .step(step), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
  endtask

  // Position of a phase along the up sequence 00 -> 10 -> 11 -> 01.
  function automatic int pos(input logic [1:0] ph);
    case (ph)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  // Model: a phase seen at edge n counts against the phase seen one edge earlier,
  // SYNC+1 edges after it was sampled; the first SYNC+1 edges after reset only settle.
  logic [1:0]       hist[$];
  int               m_edges;
  logic [WIDTH-1:0] m_cnt;
  logic             m_dir;
  logic             m_step;
  logic             m_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist.delete();
      m_edges <= 0;
      m_cnt   <= '0;
      m_dir   <= 1'b0;
      m_step  <= 1'b0;
      m_err   <= 1'b0;
    end else begin
      hist.push_back({a, b});
      if (hist.size() > SYNC + 2) hist.pop_front();
      m_step  <= 1'b0;
      m_edges <= m_edges + 1;
      if (clr) begin
        m_cnt <= '0;
        m_err <= 1'b0;
      end else if (m_edges >= SYNC + 1) begin
        case ((pos(hist[1]) - pos(hist[0])) & 3)
          1: begin m_cnt <= m_cnt + 8'd1; m_dir <= 1'b0; m_step <= 1'b1; end
          3: begin m_cnt <= m_cnt - 8'd1; m_dir <= 1'b1; m_step <= 1'b1; end
          2: m_err <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    check("model_cnt", cnt, m_cnt);
    check("model_dir", dir, m_dir);
    check("model_step", step, m_step);
    check("model_err", err, m_err);
  end

  // Applies a phase at a falling edge and samples step/err on the next hold falling
  // edges; clr is high for exactly the rising edge following sample clr_at.
  task automatic drive(input logic [1:0] ph, input int hold, input int clr_at,
                       output logic [4:0] steps, output logic [4:0] errs);
    {a, b} = ph;
    steps = '0;
    errs  = '0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (i < 5) begin
        steps[i] = step;
        errs[i]  = err;
      end
      clr = (i == clr_at);
    end
    clr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  logic [4:0] st;
  logic [4:0] er;
  logic       seen;

  initial begin
    rst_n = 1'b0;
    a = 1'b1;
    b = 1'b0;
    clr = 1'b0;
    idle(2);
    check("reset_cnt", cnt, 0);
    check("reset_err", err, 0);
    check("reset_dir", dir, 0);

    // Release while resting at phase 10: no spurious step.
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      seen |= step;
    end
    check("rest10_cnt", cnt, 0);
    check("rest10_err", err, 0);
    check("rest10_no_step", seen, 0);

    rst_n = 1'b0;
    {a, b} = 2'b00;
    idle(2);
    rst_n = 1'b1;
    idle(6);

    // Four up steps, each pulse three cycles after its input edge.
    drive(2'b10, 5, -1, st, er); check("up1_step", st, 5'b00100);
    drive(2'b11, 5, -1, st, er); check("up2_step", st, 5'b00100);
    drive(2'b01, 5, -1, st, er); check("up3_step", st, 5'b00100);
    drive(2'b00, 5, -1, st, er); check("up4_step", st, 5'b00100);
    check("up_cnt", cnt, 4);
    check("up_dir", dir, 0);
    check("up_err", err, 0);

    // Down across zero, then back up.
    drive(2'b00, 5, 0, st, er);  check("clr_cnt", cnt, 0);
    drive(2'b01, 5, -1, st, er); check("wrap_cnt", cnt, 255); check("wrap_dir", dir, 1);
    drive(2'b11, 5, -1, st, er); check("dn_cnt", cnt, 254);   check("dn_dir", dir, 1);
    drive(2'b01, 5, -1, st, er); check("rev_cnt", cnt, 255);  check("rev_dir", dir, 0);

    // Reach phase 00 with cnt=7, then an illegal jump.
    drive(2'b11, 5, -1, st, er);
    drive(2'b10, 5, -1, st, er);
    drive(2'b10, 5, 0, st, er);  check("clr10_cnt", cnt, 0);
    drive(2'b11, 5, -1, st, er);
    drive(2'b01, 5, -1, st, er);
    drive(2'b00, 5, -1, st, er);
    drive(2'b10, 5, -1, st, er);
    drive(2'b11, 5, -1, st, er);
    drive(2'b01, 5, -1, st, er);
    drive(2'b00, 5, -1, st, er); check("seven_cnt", cnt, 7);
    drive(2'b11, 5, -1, st, er);
    check("bad_err_lat", er, 5'b11100);
    check("bad_no_step", st, 0);
    check("bad_cnt", cnt, 7);
    drive(2'b10, 5, -1, st, er);
    check("after_bad_cnt", cnt, 6);
    check("sticky_err", err, 1);

    // clr coincides with the counting edge of an up step.
    drive(2'b11, 5, 1, st, er);
    check("clrwin_step", st, 0);
    check("clrwin_cnt", cnt, 0);
    check("clrwin_err", err, 0);
    check("clrwin_dir", dir, 1);
    drive(2'b01, 5, -1, st, er);
    check("post_clr_cnt", cnt, 1);
    check("post_clr_step", st, 5'b00100);

    // Load nonzero state at phase 11, then a partial-cycle reset pulse.
    drive(2'b11, 5, -1, st, er);
    drive(2'b00, 5, -1, st, er);
    drive(2'b01, 5, -1, st, er);
    drive(2'b11, 5, -1, st, er);
    check("pre_rst_cnt", cnt, 254);
    check("pre_rst_err", err, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_cnt", cnt, 0);
    check("async_rst_dir", dir, 0);
    check("async_rst_err", err, 0);
    #1 rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      seen |= step;
    end
    check("resettle_no_step", seen, 0);
    check("resettle_cnt", cnt, 0);
    drive(2'b01, 5, -1, st, er);
    check("resume_step", st, 5'b00100);
    check("resume_cnt", cnt, 1);
    check("resume_dir", dir, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
